// File: rtl/btn_reg_pkg.sv
// Shared defaults and the history opcode for the button-driven undo register file.
package btn_reg_pkg;

    localparam int WIDTH_DEF     = 4;
    localparam int DEPTH_DEF     = 4;
    localparam int DB_CYCLES_DEF = 1_000_000;

    typedef enum logic [1:0] {
        NONE,
        LOAD,
        UNDO
    } hist_op_t;

endpackage

// File: rtl/btn_debounce.sv
// Sync + debounce one active-low key, emit a single-cycle press pulse on the 1->0 edge.
// Latency: 2 sync + DB_CYCLES filter + 1 pulse register; no backpressure (free-running).
module btn_debounce
    import btn_reg_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    output logic press
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // Everything resets to "released" so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= noisy;
            sync2   <= sync1;
            level_d <= level;
            press   <= level_d & ~level;
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/btn_reg_file.sv
// Switch-loaded LED register with a circular LIFO undo history, driven by two debounced keys.
// Latency: led/hist_cnt update one cycle after a press pulse; no backpressure, load wins over undo.
module btn_reg_file
    import btn_reg_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic                       CLK50M,
    input  logic                       RSTb,
    input  logic                       load_noisy,
    input  logic                       undo_noisy,
    input  logic [WIDTH-1:0]           binary,
    output logic [WIDTH-1:0]           led,
    output logic [$clog2(DEPTH+1)-1:0] hist_cnt,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic             load_press;
    logic             undo_press;
    hist_op_t         op;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_inc;
    logic [WIDTH-1:0] hist [DEPTH];

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_load_db (
        .clk   (CLK50M),
        .rst_n (RSTb),
        .noisy (load_noisy),
        .press (load_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_undo_db (
        .clk   (CLK50M),
        .rst_n (RSTb),
        .noisy (undo_noisy),
        .press (undo_press)
    );

    // A coincident undo is dropped, not queued.
    always_comb begin
        op = NONE;
        if (load_press)
            op = LOAD;
        else if (undo_press && !empty)
            op = UNDO;
        rd_ptr = (wr_ptr == '0) ? PTR_LAST : wr_ptr - 1'b1;
        wr_inc = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    end

    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            led      <= '0;
            hist_cnt <= '0;
            wr_ptr   <= '0;
        end else begin
            case (op)
                LOAD: begin
                    led    <= binary;
                    wr_ptr <= wr_inc;
                    if (hist_cnt != CNT_FULL)
                        hist_cnt <= hist_cnt + 1'b1;
                end
                UNDO: begin
                    led      <= hist[rd_ptr];
                    wr_ptr   <= rd_ptr;
                    hist_cnt <= hist_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage is unreachable while hist_cnt is zero, so it carries no reset.
    always_ff @(posedge CLK50M) begin
        if (op == LOAD)
            hist[wr_ptr] <= led;
    end

    assign full  = (hist_cnt == CNT_FULL);
    assign empty = (hist_cnt == '0);

endmodule

// File: tb/tb_btn_reg_file.sv
// Scoreboard bench: stimulus queues expected led/hist_cnt updates, a negedge monitor checks them.
module tb_btn_reg_file;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_n = 1'b1;
    logic       undo_n = 1'b1;
    logic [3:0] binary = 4'h0;
    logic [3:0] led;
    logic [2:0] hist_cnt;
    logic       full;
    logic       empty;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] led;
        int         cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic [3:0] prev_led;
    logic [2:0] prev_cnt;

    btn_reg_file #(.WIDTH(4), .DEPTH(4), .DB_CYCLES(4)) dut (
        .CLK50M     (clk),
        .RSTb       (rst_n),
        .load_noisy (load_n),
        .undo_noisy (undo_n),
        .binary     (binary),
        .led        (led),
        .hist_cnt   (hist_cnt),
        .full       (full),
        .empty      (empty)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input logic [3:0] l, input int c, input int at);
        exp_t x;
        x.led = l;
        x.cnt = c;
        x.cyc = at;
        sb.push_back(x);
    endtask

    // Monitor: any visible change of led/hist_cnt must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (led !== prev_led || hist_cnt !== prev_cnt)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_update: led=%0h hist_cnt=%0d at cycle %0d, no update expected",
                         led, hist_cnt, cyc);
            end else begin
                e = sb.pop_front();
                chk("led", int'(led), int'(e.led));
                chk("hist_cnt", int'(hist_cnt), e.cnt);
                chk("full", int'(full), int'(e.cnt == 4));
                chk("empty", int'(empty), int'(e.cnt == 0));
                chk("update_cycle", cyc, e.cyc);
            end
        end
        prev_led = led;
        prev_cnt = hist_cnt;
    end

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d updates pending after %0d cycles, 0 required", sb.size(), budget);
            sb.delete();
        end
    endtask

    // Hold the key(s) well past qualification, release, then change binary to prove it alone does nothing.
    task automatic press(input bit ld, input bit un, input logic [3:0] b,
                         input bit chg, input logic [3:0] el, input int ec);
        @(posedge clk); #1;
        binary = b;
        if (ld) load_n = 1'b0;
        if (un) undo_n = 1'b0;
        if (chg) push(el, ec, cyc + 8);
        repeat (14) @(posedge clk);
        #1;
        load_n = 1'b1;
        undo_n = 1'b1;
        binary = ~b;
        repeat (10) @(posedge clk);
        drain(20);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_led", int'(led), 0);
        chk("reset_hist_cnt", int'(hist_cnt), 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Bounce: 0/1 every 2 cycles for 20 cycles, then settle low -> one load.
        #1;
        binary = 4'h7;
        for (int i = 0; i < 10; i++) begin
            load_n = (i % 2 == 1);
            repeat (2) @(posedge clk);
            #1;
        end
        load_n = 1'b0;
        push(4'h7, 1, cyc + 8);
        repeat (14) @(posedge clk);
        #1;
        load_n = 1'b1;
        repeat (10) @(posedge clk);
        drain(20);

        // Load 3,5,9 then undo twice.
        do_reset();
        press(1, 0, 4'h3, 1, 4'h3, 1);
        press(1, 0, 4'h5, 1, 4'h5, 2);
        press(1, 0, 4'h9, 1, 4'h9, 3);
        press(0, 1, 4'h0, 1, 4'h5, 2);
        press(0, 1, 4'h0, 1, 4'h3, 1);

        // Overflow: load 1..6 into a 4-deep history, then unwind.
        do_reset();
        press(1, 0, 4'h1, 1, 4'h1, 1);
        press(1, 0, 4'h2, 1, 4'h2, 2);
        press(1, 0, 4'h3, 1, 4'h3, 3);
        press(1, 0, 4'h4, 1, 4'h4, 4);
        press(1, 0, 4'h5, 1, 4'h5, 4);
        press(1, 0, 4'h6, 1, 4'h6, 4);
        press(0, 1, 4'h0, 1, 4'h5, 3);
        press(0, 1, 4'h0, 1, 4'h4, 2);
        press(0, 1, 4'h0, 1, 4'h3, 1);
        press(0, 1, 4'h0, 1, 4'h2, 0);
        press(0, 1, 4'h0, 0, 4'h0, 0);
        chk("undo_empty_led", int'(led), 2);
        chk("undo_empty_hist_cnt", int'(hist_cnt), 0);

        // Simultaneous load+undo: load wins, undo is discarded.
        press(1, 1, 4'hA, 1, 4'hA, 1);
        press(1, 0, 4'h4, 1, 4'h4, 2);

        // Reset mid-debounce with the load key held through release.
        @(posedge clk); #1;
        binary = 4'hC;
        load_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_led", int'(led), 0);
        chk("midreset_hist_cnt", int'(hist_cnt), 0);
        chk("midreset_empty", int'(empty), 1);
        chk("midreset_full", int'(full), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(4'hC, 1, cyc + 8);
        repeat (14) @(posedge clk);
        #1;
        load_n = 1'b1;
        repeat (10) @(posedge clk);
        drain(20);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
